// File: rtl/reset_sequencer.sv
// Staged board reset release: holds every domain in reset for HOLD_CYCLES edges,
// then releases domain 0..NUM_DOMAINS-1 in order, GAP_CYCLES edges apart.
// Latency: rst_req reaches the sequencer after a 2-flop synchronizer; all domains
//   are re-asserted by the 3rd edge after rst_req rises.
// Backpressure: none; rst_req is a level request that holds the sequence at
//   its start for as long as it stays high.
// Ports:
//   clock      - system clock
//   reset      - async active-high reset, forces all outputs to their reset values
//   rst_req    - async level-sensitive external reset request (e.g. pushbutton)
//   domain_rst - active-high per-domain resets, bit k released k-th
//   seq_busy   - high while any domain_rst bit is asserted
//   seq_done   - high once every domain has been released
//   req_count  - number of accepted rst_req assertions, saturating at 255
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rst_req,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [7:0]             req_count
);

  // Counter value on the edge that releases the final domain.
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(HOLD_CYCLES + (NUM_DOMAINS - 1) * GAP_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [7:0]             req_cnt_q, req_cnt_d;

  // Request synchronizer (req_m_q -> req_s_q) plus one delayed copy for edge detect.
  logic req_m_q, req_s_q, req_d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_m_q <= 1'b0;
      req_s_q <= 1'b0;
      req_d_q <= 1'b0;
    end else begin
      req_m_q <= rst_req;
      req_s_q <= req_m_q;
      req_d_q <= req_s_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      dom_q     <= '1;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      req_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dom_q     <= dom_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      req_cnt_q <= req_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dom_d     = dom_q;
    done_d    = done_q;
    busy_d    = busy_q;
    req_cnt_d = req_cnt_q;

    // Count request rising edges only, not the cycles the request is held.
    if (req_s_q && !req_d_q && (req_cnt_q != 8'hFF)) begin
      req_cnt_d = req_cnt_q + 8'd1;
    end

    if (req_s_q) begin
      // A live request wins over any release due on this edge and parks the
      // counter at 0, so the first edge after it drops is edge 1 again.
      state_d = ST_HOLD;
      cnt_d   = '0;
      dom_d   = '1;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD, ST_RELEASE: begin
          cnt_d = cnt_q + CNT_W'(1);
          // cnt_d is the number of the edge being taken; each domain has
          // one scheduled edge, and the counter only moves forward, so
          // releases come out in ascending order.
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (cnt_d == CNT_W'(HOLD_CYCLES + k * GAP_CYCLES)) begin
              dom_d[k] = 1'b0;
            end
          end
          // Checked first so a single-domain build goes straight to DONE.
          if (cnt_d == LAST_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (cnt_d == HOLD_CNT) begin
            state_d = ST_RELEASE;
          end
        end
        ST_DONE: begin
          // Counter frozen, all domains released.
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign domain_rst = dom_q;
  assign seq_done   = done_q;
  assign seq_busy   = busy_q;
  assign req_count  = req_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default build (4 domains, 16/8) and a
// minimal build (1 domain, hold 1) share clock, reset and rst_req.
// Expected outputs come from an edge-number model and are queued per edge.
module tb_reset_sequencer;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       rst_req = 1'b0;

  logic [3:0] dom0;
  logic       busy0, done0;
  logic [7:0] cnt0;
  logic [0:0] dom1;
  logic       busy1, done1;
  logic [7:0] cnt1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NUM_DOMAINS(4), .HOLD_CYCLES(16), .GAP_CYCLES(8), .CNT_W(16)
  ) dut0 (
    .clock(clock), .reset(reset), .rst_req(rst_req),
    .domain_rst(dom0), .seq_busy(busy0), .seq_done(done0), .req_count(cnt0)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(4)
  ) dut1 (
    .clock(clock), .reset(reset), .rst_req(rst_req),
    .domain_rst(dom1), .seq_busy(busy1), .seq_done(done1), .req_count(cnt1)
  );

  typedef struct packed {
    logic [7:0] dom;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } obs_t;

  obs_t expq0[$];
  obs_t expq1[$];

  // Reference model: sequence edge number e (0 = start / held by request),
  // saturating at the completion edge; a domain is in reset while e is
  // below its scheduled release edge.
  int m_e0  = 0;
  int m_e1  = 0;
  int m_cnt = 0;
  bit m_s0  = 1'b0;
  bit m_s1  = 1'b0;
  bit m_d   = 1'b0;

  function automatic obs_t expect_of(int n, int h, int g, int e, int cnt);
    obs_t r;
    r.dom = '0;
    for (int k = 0; k < n; k++) r.dom[k] = (e < h + k * g);
    r.done = (e >= h + (n - 1) * g);
    r.busy = !r.done;
    r.cnt  = 8'(cnt);
    return r;
  endfunction

  function automatic obs_t reset_val(int n);
    obs_t r;
    r.dom  = 8'((1 << n) - 1);
    r.busy = 1'b1;
    r.done = 1'b0;
    r.cnt  = 8'd0;
    return r;
  endfunction

  function automatic int step_e(int e, bit s, int last);
    if (s) return 0;
    return (e < last) ? e + 1 : e;
  endfunction

  always @(posedge clock) begin
    bit s;
    if (reset) begin
      m_s0 = 1'b0; m_s1 = 1'b0; m_d = 1'b0;
      m_e0 = 0; m_e1 = 0; m_cnt = 0;
    end else begin
      s = m_s1;
      if (s && !m_d && m_cnt < 255) m_cnt++;
      m_d  = s;
      m_s1 = m_s0;
      m_s0 = rst_req;
      m_e0 = step_e(m_e0, s, 16 + 3 * 8);
      m_e1 = step_e(m_e1, s, 1);
    end
    expq0.push_back(expect_of(4, 16, 8, m_e0, m_cnt));
    expq1.push_back(expect_of(1, 1, 1, m_e1, m_cnt));
  end

  task automatic check(string name, obs_t a, obs_t w);
    vectors++;
    if (a !== w) begin
      miscompares++;
      $display("FAIL %s @%0t: got dom=%b busy=%b done=%b cnt=%0d, want dom=%b busy=%b done=%b cnt=%0d",
               name, $time, a.dom, a.busy, a.done, a.cnt, w.dom, w.busy, w.done, w.cnt);
    end
  endtask

  function automatic obs_t obs0();
    obs_t a;
    a.dom = 8'(dom0); a.busy = busy0; a.done = done0; a.cnt = cnt0;
    return a;
  endfunction

  function automatic obs_t obs1();
    obs_t a;
    a.dom = 8'(dom1); a.busy = busy1; a.done = done1; a.cnt = cnt1;
    return a;
  endfunction

  // Monitor: one expected entry per edge, compared away from the edge.
  // Reset asserted between edges overrides whatever the edge produced.
  always @(negedge clock) begin
    obs_t w;
    if (expq0.size() > 0) begin
      w = expq0.pop_front();
      if (reset) w = reset_val(4);
      check("dut0_edge", obs0(), w);
    end
    if (expq1.size() > 0) begin
      w = expq1.pop_front();
      if (reset) w = reset_val(1);
      check("dut1_edge", obs1(), w);
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic cycles(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    check("async_reset_dut0", obs0(), reset_val(4));
    check("async_reset_dut1", obs1(), reset_val(1));
  endtask

  initial begin
    // Power-on sequence.
    cycles(3);
    reset = 1'b0;
    cycles(50);

    // Request held 5 cycles while DONE.
    rst_req = 1'b1;
    cycles(5);
    rst_req = 1'b0;
    cycles(50);

    // Request pulse seen on edge 28 of a fresh sequence.
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(27);
    rst_req = 1'b1;
    cycles(2);
    rst_req = 1'b0;
    cycles(60);

    // Reset asserted mid-sequence, checked before any clock edge.
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(29);
    async_reset_check();
    cycles(3);
    reset = 1'b0;
    cycles(50);

    // 300 separated pulses: req_count saturates.
    for (int i = 0; i < 300; i++) begin
      rst_req = 1'b1;
      cycles(2);
      rst_req = 1'b0;
      cycles(3);
    end
    cycles(60);

    // Random mix of requests, resets and idle stretches.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        async_reset_check();
        cycles($urandom_range(1, 3));
        reset = 1'b0;
      end else if (r < 5) begin
        rst_req = 1'b1;
        cycles($urandom_range(1, 6));
        rst_req = 1'b0;
      end
      cycles($urandom_range(1, 45));
    end
    cycles(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
